// File: rtl/mem_bank_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bank_rr_arbiter
// Purpose  : Round-robin arbiter sharing one in-order banked-memory port among
//            NUM_REQ requesters; an ID FIFO routes responses to their issuers.
// Revision : 1.0  initial release
// ============================================================================
module mem_bank_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_TRANS  = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NUM_REQ-1:0]                 req_i,
  output logic [NUM_REQ-1:0]                 gnt_o,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]      addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      wdata_i,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]  strb_i,
  input  logic [NUM_REQ-1:0]                 we_i,
  output logic [NUM_REQ-1:0]                 rvalid_o,
  output logic [DATA_WIDTH-1:0]              rdata_o,
  output logic                               mst_req_o,
  input  logic                               mst_gnt_i,
  output logic [ADDR_WIDTH-1:0]              mst_addr_o,
  output logic [DATA_WIDTH-1:0]              mst_wdata_o,
  output logic [DATA_WIDTH/8-1:0]            mst_strb_o,
  output logic                               mst_we_o,
  input  logic                               mst_rvalid_i,
  input  logic [DATA_WIDTH-1:0]              mst_rdata_i,
  output logic                               err_o
);

  localparam int c_STRB_W = DATA_WIDTH / 8;
  localparam int c_ID_W   = $clog2(NUM_REQ);
  localparam int c_PTR_W  = (MAX_TRANS > 1) ? $clog2(MAX_TRANS) : 1;
  localparam int c_CNT_W  = $clog2(MAX_TRANS + 1);

  logic [c_ID_W-1:0]  r_rr;
  logic               r_lock;
  logic [c_ID_W-1:0]  r_sel;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic               r_err;
  logic [c_ID_W-1:0]  r_fifo [MAX_TRANS];

  logic [c_ID_W-1:0]  w_scan_sel;
  logic [c_ID_W-1:0]  w_sel;
  logic [c_ID_W-1:0]  w_head;
  logic               w_stall;
  logic               w_hs;
  logic               w_pop;

  function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_W'(MAX_TRANS - 1)) ? '0 : p + c_PTR_W'(1);
  endfunction

  // First requesting index at or after the round-robin pointer.
  always_comb begin
    logic found;
    int   idx;
    w_scan_sel = r_rr;
    found      = 1'b0;
    idx        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(r_rr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_i[c_ID_W'(idx)]) begin
        found      = 1'b1;
        w_scan_sel = c_ID_W'(idx);
      end
    end
  end

  assign w_sel     = r_lock ? r_sel : w_scan_sel;
  assign w_stall   = (r_cnt == c_CNT_W'(MAX_TRANS));
  assign mst_req_o = (r_lock | (|req_i)) & ~w_stall;
  assign w_hs      = mst_req_o & mst_gnt_i;
  assign w_pop     = mst_rvalid_i & (r_cnt != '0);
  assign w_head    = r_fifo[r_rptr];

  assign mst_addr_o  = mst_req_o ? addr_i[w_sel*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign mst_wdata_o = mst_req_o ? wdata_i[w_sel*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign mst_strb_o  = mst_req_o ? strb_i[w_sel*c_STRB_W +: c_STRB_W] : '0;
  assign mst_we_o    = mst_req_o & we_i[w_sel];
  assign rdata_o     = mst_rdata_i;
  assign err_o       = r_err;

  always_comb begin
    gnt_o    = '0;
    rvalid_o = '0;
    if (w_hs)  gnt_o[w_sel]     = 1'b1;
    if (w_pop) rvalid_o[w_head] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr   <= '0;
      r_lock <= 1'b0;
      r_sel  <= '0;
      r_cnt  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_hs) begin
        r_lock <= 1'b0;
        r_rr   <= (w_sel == c_ID_W'(NUM_REQ - 1)) ? '0 : w_sel + c_ID_W'(1);
        r_wptr <= ptr_inc(r_wptr);
      end else if (mst_req_o) begin
        // Hold the stalled requester's payload until the port accepts it.
        r_lock <= 1'b1;
        r_sel  <= w_sel;
      end
      if (w_pop) r_rptr <= ptr_inc(r_rptr);
      case ({w_hs, w_pop})
        2'b10:   r_cnt <= r_cnt + c_CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - c_CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (mst_rvalid_i && (r_cnt == '0)) r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && w_hs) r_fifo[r_wptr] <= w_sel;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_bank_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bank_rr_arbiter
// Purpose  : Directed self-checking bench for mem_bank_rr_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_bank_rr_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req, gnt, we, rvalid;
  logic [127:0] addr, wdata;
  logic [15:0]  strb;
  logic [31:0]  rdata;
  logic         mst_req, mst_gnt, mst_we, mst_rvalid, err;
  logic [31:0]  mst_addr, mst_wdata, mst_rdata;
  logic [3:0]   mst_strb;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_bank_rr_arbiter #(
    .NUM_REQ(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_TRANS(4)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .addr_i(addr),
    .wdata_i(wdata), .strb_i(strb), .we_i(we), .rvalid_o(rvalid),
    .rdata_o(rdata), .mst_req_o(mst_req), .mst_gnt_i(mst_gnt),
    .mst_addr_o(mst_addr), .mst_wdata_o(mst_wdata), .mst_strb_o(mst_strb),
    .mst_we_o(mst_we), .mst_rvalid_i(mst_rvalid), .mst_rdata_i(mst_rdata),
    .err_o(err)
  );

  task automatic set_addr(input int i, input logic [31:0] a);
    addr[i*32 +: 32] = a;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1; req = 4'b1111; mst_gnt = 1'b1; mst_rvalid = 1'b0;
    @(negedge clk); rst = 1'b0; req = 4'b0000; mst_gnt = 1'b0; #1;
    total++;
    if ({gnt, rvalid, mst_req, mst_we, err} !== 11'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=0", {gnt, rvalid, mst_req, mst_we, err});
    end
    total++;
    if ({mst_addr, mst_wdata, mst_strb} !== 68'h0) begin
      bad++; $display("FAIL reset_payload got=%h exp=0", {mst_addr, mst_wdata, mst_strb});
    end
  endtask

  task automatic test_fairness();
    logic [3:0]  exp_gnt, exp_rv;
    logic [31:0] exp_addr;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      req = (k < 5) ? 4'b1111 : 4'b0000; mst_gnt = 1'b1;
      mst_rvalid = (k > 0); mst_rdata = 32'hD0 + k; #1;
      exp_gnt  = (k < 5) ? 4'(1 << (k % 4)) : 4'b0000;
      exp_rv   = (k > 0) ? 4'(1 << ((k - 1) % 4)) : 4'b0000;
      exp_addr = 32'h1000 + 32'((k % 4) * 16);
      total++;
      if (gnt !== exp_gnt) begin
        bad++; $display("FAIL fair_gnt k=%0d got=%b exp=%b", k, gnt, exp_gnt);
      end
      total++;
      if (rvalid !== exp_rv) begin
        bad++; $display("FAIL fair_rvalid k=%0d got=%b exp=%b", k, rvalid, exp_rv);
      end
      if (k < 5) begin
        total++;
        if (mst_addr !== exp_addr) begin
          bad++; $display("FAIL fair_addr k=%0d got=%h exp=%h", k, mst_addr, exp_addr);
        end
      end
      if (k > 0) begin
        total++;
        if (rdata !== 32'hD0 + k) begin
          bad++; $display("FAIL fair_rdata k=%0d got=%h exp=%h", k, rdata, 32'hD0 + k);
        end
      end
    end
    @(negedge clk); req = 4'b0000; mst_gnt = 1'b0; mst_rvalid = 1'b0;
  endtask

  task automatic test_lock();
    // Grant requester 3 so the pointer lands on 0 and requester 0 would win unlocked.
    @(negedge clk); req = 4'b1000; mst_gnt = 1'b1; #1;
    total++;
    if (gnt !== 4'b1000) begin bad++; $display("FAIL lock_pre_gnt got=%b exp=1000", gnt); end
    @(negedge clk); req = 4'b0000; mst_gnt = 1'b0; mst_rvalid = 1'b1; #1;
    total++;
    if (rvalid !== 4'b1000) begin bad++; $display("FAIL lock_pre_rv got=%b exp=1000", rvalid); end
    @(negedge clk); mst_rvalid = 1'b0; req = 4'b0100; #1;
    total++;
    if ({mst_req, gnt, mst_addr} !== {1'b1, 4'b0000, 32'h1020}) begin
      bad++; $display("FAIL lock_c0 got=%b/%b/%h exp=1/0000/00001020", mst_req, gnt, mst_addr);
    end
    for (int k = 1; k < 3; k++) begin
      @(negedge clk); req = 4'b0101; #1;
      total++;
      if ({gnt, mst_addr} !== {4'b0000, 32'h1020}) begin
        bad++; $display("FAIL lock_hold k=%0d got=%b/%h exp=0000/00001020", k, gnt, mst_addr);
      end
    end
    @(negedge clk); mst_gnt = 1'b1; #1;
    total++;
    if ({gnt, mst_addr} !== {4'b0100, 32'h1020}) begin
      bad++; $display("FAIL lock_gnt got=%b/%h exp=0100/00001020", gnt, mst_addr);
    end
    @(negedge clk); req = 4'b0001; #1;
    total++;
    if ({gnt, mst_addr} !== {4'b0001, 32'h1000}) begin
      bad++; $display("FAIL lock_next got=%b/%h exp=0001/00001000", gnt, mst_addr);
    end
    @(negedge clk); req = 4'b0000; mst_gnt = 1'b0; mst_rvalid = 1'b1; #1;
    total++;
    if (rvalid !== 4'b0100) begin bad++; $display("FAIL lock_rv0 got=%b exp=0100", rvalid); end
    @(negedge clk); #1;
    total++;
    if (rvalid !== 4'b0001) begin bad++; $display("FAIL lock_rv1 got=%b exp=0001", rvalid); end
    @(negedge clk); mst_rvalid = 1'b0;
  endtask

  task automatic test_stall();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); req = 4'b0001; mst_gnt = 1'b1; #1;
      total++;
      if (gnt !== 4'b0001) begin bad++; $display("FAIL stall_fill k=%0d got=%b exp=0001", k, gnt); end
    end
    @(negedge clk); #1;
    total++;
    if ({mst_req, gnt} !== 5'b0) begin bad++; $display("FAIL stall_full got=%b/%b exp=0/0000", mst_req, gnt); end
    @(negedge clk); mst_rvalid = 1'b1; #1;
    total++;
    if ({mst_req, rvalid} !== {1'b0, 4'b0001}) begin
      bad++; $display("FAIL stall_pop_same got=%b/%b exp=0/0001", mst_req, rvalid);
    end
    @(negedge clk); mst_rvalid = 1'b0; #1;
    total++;
    if ({mst_req, gnt} !== {1'b1, 4'b0001}) begin
      bad++; $display("FAIL stall_release got=%b/%b exp=1/0001", mst_req, gnt);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); req = 4'b0000; mst_gnt = 1'b0; mst_rvalid = 1'b1; #1;
      total++;
      if (rvalid !== 4'b0001) begin bad++; $display("FAIL stall_drain k=%0d got=%b exp=0001", k, rvalid); end
    end
    @(negedge clk); mst_rvalid = 1'b0;
  endtask

  task automatic test_routing();
    logic [3:0]  exp_rv [3];
    logic [31:0] exp_rd [3];
    exp_rv = '{4'b1000, 4'b0010, 4'b1000};
    exp_rd = '{32'hA, 32'hB, 32'hC};
    set_addr(3, 32'h30); set_addr(1, 32'h10);
    @(negedge clk); req = 4'b1000; mst_gnt = 1'b1; #1;
    total++;
    if ({gnt, mst_addr} !== {4'b1000, 32'h30}) begin bad++; $display("FAIL route_g0 got=%b/%h exp=1000/30", gnt, mst_addr); end
    @(negedge clk); req = 4'b0010; #1;
    total++;
    if ({gnt, mst_addr} !== {4'b0010, 32'h10}) begin bad++; $display("FAIL route_g1 got=%b/%h exp=0010/10", gnt, mst_addr); end
    @(negedge clk); req = 4'b1000; set_addr(3, 32'h34); #1;
    total++;
    if ({gnt, mst_addr} !== {4'b1000, 32'h34}) begin bad++; $display("FAIL route_g2 got=%b/%h exp=1000/34", gnt, mst_addr); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); req = 4'b0000; mst_gnt = 1'b0; mst_rvalid = 1'b1; mst_rdata = exp_rd[k]; #1;
      total++;
      if ({rvalid, rdata} !== {exp_rv[k], exp_rd[k]}) begin
        bad++; $display("FAIL route_rsp k=%0d got=%b/%h exp=%b/%h", k, rvalid, rdata, exp_rv[k], exp_rd[k]);
      end
    end
    @(negedge clk); mst_rvalid = 1'b0;
  endtask

  task automatic test_error();
    @(negedge clk); mst_rvalid = 1'b1; mst_rdata = 32'hEE; #1;
    total++;
    if ({rvalid, err} !== 5'b0) begin bad++; $display("FAIL err_drop got=%b/%b exp=0000/0", rvalid, err); end
    @(negedge clk); mst_rvalid = 1'b0; #1;
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", err); end
    @(negedge clk); #1;
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL err_hold got=%b exp=1", err); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", err); end
    // Reset with one transaction outstanding must forget its ID.
    @(negedge clk); req = 4'b0001; mst_gnt = 1'b1; #1;
    total++;
    if (gnt !== 4'b0001) begin bad++; $display("FAIL err_mid_gnt got=%b exp=0001", gnt); end
    @(negedge clk); req = 4'b0000; mst_gnt = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0; mst_rvalid = 1'b1; #1;
    total++;
    if (rvalid !== 4'b0000) begin bad++; $display("FAIL err_mid_rv got=%b exp=0000", rvalid); end
    @(negedge clk); mst_rvalid = 1'b0; #1;
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL err_mid_set got=%b exp=1", err); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [3:0] exp_rv [4];
    exp_rv = '{4'b0010, 4'b0100, 4'b1000, 4'b1000};
    @(negedge clk); req = 4'b0001; mst_gnt = 1'b1; #1;
    total++;
    if (gnt !== 4'b0001) begin bad++; $display("FAIL sim_g0 got=%b exp=0001", gnt); end
    @(negedge clk); req = 4'b0010; #1;
    total++;
    if (gnt !== 4'b0010) begin bad++; $display("FAIL sim_g1 got=%b exp=0010", gnt); end
    @(negedge clk); req = 4'b0100; mst_rvalid = 1'b1; mst_rdata = 32'h55; #1;
    total++;
    if ({gnt, rvalid} !== {4'b0100, 4'b0001}) begin
      bad++; $display("FAIL sim_both got=%b/%b exp=0100/0001", gnt, rvalid);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); mst_rvalid = 1'b0; req = 4'b1000; #1;
      total++;
      if (gnt !== 4'b1000) begin bad++; $display("FAIL sim_fill k=%0d got=%b exp=1000", k, gnt); end
    end
    @(negedge clk); #1;
    total++;
    if (mst_req !== 1'b0) begin bad++; $display("FAIL sim_stall got=%b exp=0", mst_req); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); req = 4'b0000; mst_gnt = 1'b0; mst_rvalid = 1'b1; #1;
      total++;
      if (rvalid !== exp_rv[k]) begin bad++; $display("FAIL sim_drain k=%0d got=%b exp=%b", k, rvalid, exp_rv[k]); end
    end
    @(negedge clk); mst_rvalid = 1'b0; #1;
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL sim_err got=%b exp=0", err); end
  endtask

  initial begin
    rst = 1'b1; req = '0; we = 4'b1010; mst_gnt = 1'b0; mst_rvalid = 1'b0; mst_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      addr[i*32 +: 32]  = 32'h1000 + 32'(i * 16);
      wdata[i*32 +: 32] = 32'hCAFE0000 + 32'(i);
      strb[i*4 +: 4]    = 4'(i + 1);
    end
    test_reset();
    test_fairness();
    test_lock();
    test_stall();
    test_routing();
    test_error();
    test_simultaneous();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
